mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  MEM-stage load/store unit directly downstream of the EX-stage ALU. It takes the ALU result as the
//  effective address (or as pass-through data), drives a req/ack data-memory port and aligns byte lanes.
//  It sign/zero-extends load data and presents registered results to WB.
//  While a memory access is outstanding it stalls upstream.
// PARAMETERS
//  MAX_WAIT  16  cycles allowed between dmem_req rising and dmem_ack before a bus error is declared
// PORTS
//  clk            in   1   clock
//  rst            in   1   reset; synchronous, active-high
//  ex_valid       in   1   EX presents a valid instruction this cycle
//  ex_alu_result  in   32  ALU result: effective address for ld/st, else writeback data
//  ex_store_data  in   32  rs2 value for stores
//  ex_mem_read    in   1   load instruction
//  ex_mem_write   in   1   store instruction
//  ex_funct3      in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ex_rd          in   5   destination register
//  ex_reg_write   in   1   instruction writes rd
//  mem_stall      out  1   hold EX/ID/IF; EX inputs are ignored while high
//  dmem_req       out  1   memory request, held until dmem_ack
//  dmem_we        out  1   1 = write
//  dmem_addr      out  32  word address, ex_alu_result with [1:0] forced to 0
//  dmem_be        out  4   byte enables
//  dmem_wdata     out  32  lane-replicated store data
//  dmem_rdata     in   32  read word, valid when dmem_ack
//  dmem_ack       in   1   access complete (single-cycle pulse)
//  wb_valid       out  1   WB outputs valid (1-cycle pulse per instruction)
//  wb_reg_write   out  1   write rd
//  wb_rd          out  5   destination register
//  wb_data        out  32  aligned/extended load data or pass-through ALU result
//  wb_exc         out  2   00 none, 01 misaligned, 10 bus timeout; wb_reg_write=0 when nonzero
// BEHAVIOUR
//  - Reset: state IDLE, wait counter 0, all outputs 0. Reset mid-access drops dmem_req next cycle; no WB.
//  - FSM IDLE / WAIT. mem_stall = (state==WAIT) && !dmem_ack && !timeout.
//  - IDLE, ex_valid, no mem op: register result -> wb_valid=1 next cycle with wb_data=ex_alu_result. Latency 1.
//  - IDLE, ex_valid, mem op, aligned: latch addr/be/wdata/we/rd/funct3; next cycle state=WAIT, dmem_req=1.
//  - IDLE, mem op, misaligned: no request; next cycle wb_valid=1, wb_exc=01, wb_reg_write=0.
//    Misaligned means H/HU/SH with addr[0]=1, or W/SW with addr[1:0]!=0.
//  - ex_mem_read && ex_mem_write both set: treated as a store; wb_reg_write=0.
//  - funct3 011/110/111: treated as W.
//  - WAIT: dmem_* held stable and EX inputs ignored. Counter increments every cycle.
//    On dmem_ack: dmem_req=0 and state=IDLE next cycle. Load data is formatted and registered:
//    wb_valid=1 on the cycle after ack. Store: wb_valid=1 with wb_reg_write=0.
//  - Timeout: counter==MAX_WAIT-1 without ack -> dmem_req=0, state=IDLE; next cycle wb_valid=1, wb_exc=10.
//    An ack arriving in the same cycle as timeout wins (normal completion).
//  - Store lanes: SB be=1<<a[1:0], wdata={4{b}}; SH be=a[1]?1100:0011, wdata={2{h}}; SW be=1111.
//  - Load extract: byte=rdata[8*a[1:0]+:8], half=rdata[16*a[1]+:16]. B/H sign-extend, BU/HU zero-extend.
//  - Load with rd=0: access performed, wb_reg_write forced 0.
//  - Back-to-back: an instruction presented in the ack cycle has already been retired upstream and is ignored.
//    The next instruction is accepted in the following IDLE cycle (no bubble beyond that).
// STRUCTURE
//  - Shared package riscv_pkg: funct3 size codes, the wb_exc codes, and the FSM state localparams.
//  - One combinational sub-module, mem_align: store lane/be generation, misalignment detect,
//    load extract/extend. The FSM, counter and WB registers stay in mem_lsu.
// TESTING
//  - ALU pass-through: ex_alu_result=0x1234_5678, rd=5, no mem op -> next cycle wb_valid=1,
//    wb_data=0x12345678, wb_rd=5, mem_stall never 1.
//  - LB at addr 0x1003, rdata=0x80AB_CDEF, ack after 3 cycles -> dmem_addr=0x1000, mem_stall high
//    3 cycles, wb_data=0xFFFFFF80. Same access as LBU -> wb_data=0x00000080.
//  - SH at 0x2002, store_data=0x0000_BEEF -> dmem_we=1, be=1100, wdata=0xBEEF_BEEF, wb_reg_write=0.
//  - LW at 0x3001 -> no dmem_req, wb_exc=01, wb_reg_write=0. SH at 0x3001 -> wb_exc=01 likewise.
//  - LW with ack withheld -> dmem_req drops after MAX_WAIT=16 cycles, wb_exc=10; then ack at cycle 16 -> normal.
//  - rst asserted during WAIT -> dmem_req=0 and wb_valid=0 next cycle. A load issued after reset completes correctly.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared definitions for the MEM-stage load/store unit: funct3 access codes,
// writeback exception codes, FSM state encodings and access-size helpers.
package riscv_pkg;

  // funct3 access size/sign codes
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Writeback exception codes
  localparam logic [1:0] EXC_NONE     = 2'b00;
  localparam logic [1:0] EXC_MISALIGN = 2'b01;
  localparam logic [1:0] EXC_TIMEOUT  = 2'b10;

  // FSM states
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } size_e;

  // Unlisted funct3 encodings (011/110/111) fall back to a word access.
  function automatic size_e decode_size(input logic [2:0] funct3);
    size_e size;
    case (funct3)
      F3_B, F3_BU: size = SzByte;
      F3_H, F3_HU: size = SzHalf;
      F3_W:        size = SzWord;
      default:     size = SzWord;
    endcase
    return size;
  endfunction

  function automatic logic is_unsigned(input logic [2:0] funct3);
    return (funct3 == F3_BU) || (funct3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Combinational byte-lane logic: store lane replication and byte enables,
// misalignment detection, and load byte/half extraction with sign/zero extension.
module mem_align
  import riscv_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_addr_i,
  input  logic [31:0] st_data_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic        misaligned_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_addr_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] ld_data_o
);

  size_e       st_size;
  size_e       ld_size;
  logic        ld_uns;
  logic [31:0] ld_shift;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign st_size = decode_size(st_funct3_i);
  assign ld_size = decode_size(ld_funct3_i);
  assign ld_uns  = is_unsigned(ld_funct3_i);

  // Request-side lane steering and alignment check for the access presented by EX.
  always_comb begin
    be_o         = 4'b0000;
    wdata_o      = 32'h0;
    misaligned_o = 1'b0;
    case (st_size)
      SzByte: begin
        be_o    = 4'b0001 << st_addr_i;
        wdata_o = {4{st_data_i[7:0]}};
      end
      SzHalf: begin
        be_o         = st_addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_o      = {2{st_data_i[15:0]}};
        misaligned_o = st_addr_i[0];
      end
      default: begin
        be_o         = 4'b1111;
        wdata_o      = st_data_i;
        misaligned_o = |st_addr_i;
      end
    endcase
  end

  // Response-side extraction using the latched access size and address offset.
  always_comb begin
    ld_shift = rdata_i >> {ld_addr_i, 3'b000};
    ld_byte  = ld_shift[7:0];
    ld_half  = ld_addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (ld_size)
      SzByte:  ld_data_o = ld_uns ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      SzHalf:  ld_data_o = ld_uns ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// MEM-stage load/store unit: issues req/ack data-memory accesses from the
// EX-stage ALU result, stalls upstream while an access is outstanding, and
// presents registered single-cycle writeback results.
module mem_lsu
  import riscv_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_store_data,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic [2:0]  ex_funct3,
  input  logic [4:0]  ex_rd,
  input  logic        ex_reg_write,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        wb_valid,
  output logic        wb_reg_write,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic [1:0]  wb_exc
);

  localparam int unsigned CntW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(MAX_WAIT - 1);

  logic [0:0]      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [31:0]     addr_q, addr_d;
  logic [1:0]      addr_lo_q, addr_lo_d;
  logic [3:0]      be_q, be_d;
  logic [31:0]     wdata_q, wdata_d;
  logic [4:0]      rd_q, rd_d;
  logic [2:0]      funct3_q, funct3_d;
  logic            ld_wr_q, ld_wr_d;

  logic            wb_valid_q, wb_valid_d;
  logic            wb_reg_write_q, wb_reg_write_d;
  logic [4:0]      wb_rd_q, wb_rd_d;
  logic [31:0]     wb_data_q, wb_data_d;
  logic [1:0]      wb_exc_q, wb_exc_d;

  logic [3:0]      al_be;
  logic [31:0]     al_wdata;
  logic            al_misaligned;
  logic [31:0]     al_ld_data;
  logic            in_wait;
  logic            timeout;
  logic            mem_op;

  mem_align u_mem_align (
    .st_funct3_i  (ex_funct3),
    .st_addr_i    (ex_alu_result[1:0]),
    .st_data_i    (ex_store_data),
    .be_o         (al_be),
    .wdata_o      (al_wdata),
    .misaligned_o (al_misaligned),
    .ld_funct3_i  (funct3_q),
    .ld_addr_i    (addr_lo_q),
    .rdata_i      (dmem_rdata),
    .ld_data_o    (al_ld_data)
  );

  assign in_wait   = (state_q == ST_WAIT);
  // A same-cycle ack takes priority over the timeout.
  assign timeout   = in_wait && !dmem_ack && (cnt_q == CntLast);
  assign mem_stall = in_wait && !dmem_ack && !timeout;
  assign mem_op    = ex_mem_read || ex_mem_write;

  // Next-state: accept from EX in IDLE, track the outstanding access in WAIT.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    req_d          = req_q;
    we_d           = we_q;
    addr_d         = addr_q;
    addr_lo_d      = addr_lo_q;
    be_d           = be_q;
    wdata_d        = wdata_q;
    rd_d           = rd_q;
    funct3_d       = funct3_q;
    ld_wr_d        = ld_wr_q;
    wb_valid_d     = 1'b0;
    wb_reg_write_d = wb_reg_write_q;
    wb_rd_d        = wb_rd_q;
    wb_data_d      = wb_data_q;
    wb_exc_d       = wb_exc_q;

    if (state_q == ST_IDLE) begin
      if (ex_valid) begin
        if (!mem_op) begin
          wb_valid_d     = 1'b1;
          wb_reg_write_d = ex_reg_write;
          wb_rd_d        = ex_rd;
          wb_data_d      = ex_alu_result;
          wb_exc_d       = EXC_NONE;
        end else if (al_misaligned) begin
          wb_valid_d     = 1'b1;
          wb_reg_write_d = 1'b0;
          wb_rd_d        = ex_rd;
          wb_data_d      = ex_alu_result;
          wb_exc_d       = EXC_MISALIGN;
        end else begin
          // Read+write together is a store, so only a pure read writes back.
          state_d   = ST_WAIT;
          cnt_d     = '0;
          req_d     = 1'b1;
          we_d      = ex_mem_write;
          addr_d    = {ex_alu_result[31:2], 2'b00};
          addr_lo_d = ex_alu_result[1:0];
          be_d      = al_be;
          wdata_d   = al_wdata;
          rd_d      = ex_rd;
          funct3_d  = ex_funct3;
          ld_wr_d   = !ex_mem_write && ex_reg_write && (ex_rd != 5'd0);
        end
      end
    end else begin
      if (dmem_ack) begin
        state_d        = ST_IDLE;
        req_d          = 1'b0;
        wb_valid_d     = 1'b1;
        wb_rd_d        = rd_q;
        wb_exc_d       = EXC_NONE;
        wb_reg_write_d = we_q ? 1'b0 : ld_wr_q;
        wb_data_d      = we_q ? 32'h0 : al_ld_data;
      end else if (timeout) begin
        state_d        = ST_IDLE;
        req_d          = 1'b0;
        wb_valid_d     = 1'b1;
        wb_rd_d        = rd_q;
        wb_exc_d       = EXC_TIMEOUT;
        wb_reg_write_d = 1'b0;
        wb_data_d      = 32'h0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      req_q          <= 1'b0;
      we_q           <= 1'b0;
      addr_q         <= 32'h0;
      addr_lo_q      <= 2'b00;
      be_q           <= 4'b0000;
      wdata_q        <= 32'h0;
      rd_q           <= 5'd0;
      funct3_q       <= 3'b000;
      ld_wr_q        <= 1'b0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      wb_rd_q        <= 5'd0;
      wb_data_q      <= 32'h0;
      wb_exc_q       <= EXC_NONE;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      req_q          <= req_d;
      we_q           <= we_d;
      addr_q         <= addr_d;
      addr_lo_q      <= addr_lo_d;
      be_q           <= be_d;
      wdata_q        <= wdata_d;
      rd_q           <= rd_d;
      funct3_q       <= funct3_d;
      ld_wr_q        <= ld_wr_d;
      wb_valid_q     <= wb_valid_d;
      wb_reg_write_q <= wb_reg_write_d;
      wb_rd_q        <= wb_rd_d;
      wb_data_q      <= wb_data_d;
      wb_exc_q       <= wb_exc_d;
    end
  end

  assign dmem_req     = req_q;
  assign dmem_we      = we_q;
  assign dmem_addr    = addr_q;
  assign dmem_be      = be_q;
  assign dmem_wdata   = wdata_q;
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign wb_rd        = wb_rd_q;
  assign wb_data      = wb_data_q;
  assign wb_exc       = wb_exc_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: per-scenario tasks drive EX and the memory
// port; expected writebacks go into a queue and are compared as WB fires.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        wb_valid;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic [1:0]  wb_exc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
    logic [1:0]  exc;
    logic        chk_data;
    int          tag;
  } exp_t;

  exp_t exp_q[$];

  mem_lsu #(.MAX_WAIT(16)) dut (
    .clk           (clk),
    .rst           (rst),
    .ex_valid      (ex_valid),
    .ex_alu_result (ex_alu_result),
    .ex_store_data (ex_store_data),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_funct3     (ex_funct3),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .mem_stall     (mem_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_rdata    (dmem_rdata),
    .dmem_ack      (dmem_ack),
    .wb_valid      (wb_valid),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .wb_exc        (wb_exc)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input int tag, input logic rw, input logic [4:0] rd,
                          input logic [31:0] data, input logic [1:0] exc, input logic chk);
    exp_t e;
    e.tag = tag; e.rw = rw; e.rd = rd; e.data = data; e.exc = exc; e.chk_data = chk;
    exp_q.push_back(e);
  endtask

  // Scoreboard consumer: every WB pulse must match the oldest expectation.
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL wb_unexpected got rd=%0d data=%h exc=%b required no writeback",
                   wb_rd, wb_data, wb_exc);
        end else begin
          e = exp_q.pop_front();
          if (wb_reg_write !== e.rw || wb_rd !== e.rd || wb_exc !== e.exc ||
              (e.chk_data && wb_data !== e.data)) begin
            errors++;
            $display("FAIL wb_tag%0d got rw=%b rd=%0d data=%h exc=%b required rw=%b rd=%0d data=%h exc=%b",
                     e.tag, wb_reg_write, wb_rd, wb_data, wb_exc, e.rw, e.rd, e.data, e.exc);
          end
        end
      end
    end
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
  endtask

  // Present one instruction for one cycle; returns just after the accepting edge.
  task automatic issue(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                       input logic mr, input logic mw, input logic [2:0] f3, input logic rw);
    ex_valid = 1'b1; ex_alu_result = alu; ex_store_data = sd; ex_rd = rd;
    ex_mem_read = mr; ex_mem_write = mw; ex_funct3 = f3; ex_reg_write = rw;
    @(posedge clk); #1;
    idle_inputs();
  endtask

  // Hold ack low n_wait cycles, then pulse it with rdata.
  task automatic serve(input int n_wait, input logic [31:0] rdata, output int stalls);
    stalls = 0;
    for (int i = 0; i < n_wait; i++) begin
      checks++;
      if (dmem_req !== 1'b1) begin
        errors++; $display("FAIL serve_req_held got %b required 1 at wait %0d", dmem_req, i);
      end
      if (mem_stall === 1'b1) stalls++;
      @(posedge clk); #1;
    end
    dmem_rdata = rdata; dmem_ack = 1'b1; #1;
    checks++;
    if (mem_stall !== 1'b0) begin
      errors++; $display("FAIL serve_stall_on_ack got %b required 0", mem_stall);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++; $display("FAIL serve_req_drop got %b required 0", dmem_req);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; idle_inputs(); dmem_ack = 1'b0; dmem_rdata = 32'h0;
    ex_alu_result = 32'h0; ex_store_data = 32'h0; ex_funct3 = 3'b0; ex_rd = 5'd0;
    ex_reg_write = 1'b0;
    repeat (3) @(posedge clk); #1;
    checks++;
    if ({mem_stall, dmem_req, dmem_we, dmem_be, wb_valid, wb_reg_write, wb_exc} !== 11'h0 ||
        dmem_addr !== 32'h0 || wb_data !== 32'h0 || wb_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_state got stall=%b req=%b be=%b wbv=%b exc=%b data=%h required all 0",
               mem_stall, dmem_req, dmem_be, wb_valid, wb_exc, wb_data);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_passthru();
    int stalls = 0;
    push_exp(1, 1'b1, 5'd5, 32'h1234_5678, 2'b00, 1'b1);
    issue(32'h1234_5678, 32'h0, 5'd5, 1'b0, 1'b0, 3'b010, 1'b1);
    checks++;
    if (wb_valid !== 1'b1) begin
      errors++; $display("FAIL passthru_latency got wb_valid=%b required 1", wb_valid);
    end
    for (int i = 0; i < 3; i++) begin
      if (mem_stall !== 1'b0) stalls++;
      @(posedge clk); #1;
    end
    checks++;
    if (stalls != 0) begin
      errors++; $display("FAIL passthru_stall got %0d stall cycles required 0", stalls);
    end
  endtask

  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp_data, input int tag);
    int stalls;
    push_exp(tag, 1'b1, 5'd7, exp_data, 2'b00, 1'b1);
    issue(32'h0000_1003, 32'h0, 5'd7, 1'b1, 1'b0, f3, 1'b1);
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== 32'h1000 || dmem_be !== 4'b1000) begin
      errors++;
      $display("FAIL load_req got req=%b we=%b addr=%h be=%b required 1 0 00001000 1000",
               dmem_req, dmem_we, dmem_addr, dmem_be);
    end
    serve(3, 32'h80AB_CDEF, stalls);
    checks++;
    if (stalls != 3) begin
      errors++; $display("FAIL load_stall_cycles got %0d required 3", stalls);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_store_half();
    int stalls;
    push_exp(4, 1'b0, 5'd0, 32'h0, 2'b00, 1'b0);
    issue(32'h0000_2002, 32'h0000_BEEF, 5'd0, 1'b0, 1'b1, 3'b001, 1'b0);
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h2000 ||
        dmem_be !== 4'b1100 || dmem_wdata !== 32'hBEEF_BEEF) begin
      errors++;
      $display("FAIL store_half got req=%b we=%b addr=%h be=%b wdata=%h required 1 1 00002000 1100 beefbeef",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata);
    end
    serve(1, 32'h0, stalls);
    // Read+write together acts as a store: no register write.
    push_exp(5, 1'b0, 5'd3, 32'h0, 2'b00, 1'b0);
    issue(32'h0000_2001, 32'h0000_00A5, 5'd3, 1'b1, 1'b1, 3'b000, 1'b1);
    checks++;
    if (dmem_we !== 1'b1 || dmem_be !== 4'b0010 || dmem_wdata !== 32'hA5A5_A5A5) begin
      errors++;
      $display("FAIL store_byte_rw got we=%b be=%b wdata=%h required 1 0010 a5a5a5a5",
               dmem_we, dmem_be, dmem_wdata);
    end
    serve(0, 32'h0, stalls);
    @(posedge clk); #1;
  endtask

  task automatic test_misaligned();
    push_exp(6, 1'b0, 5'd8, 32'h0, 2'b01, 1'b0);
    issue(32'h0000_3001, 32'h0, 5'd8, 1'b1, 1'b0, 3'b010, 1'b1);
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL misalign_lw got req=%b stall=%b required 0 0", dmem_req, mem_stall);
    end
    push_exp(7, 1'b0, 5'd0, 32'h0, 2'b01, 1'b0);
    issue(32'h0000_3001, 32'h1111, 5'd0, 1'b0, 1'b1, 3'b001, 1'b0);
    checks++;
    if (dmem_req !== 1'b0 || mem_stall !== 1'b0) begin
      errors++; $display("FAIL misalign_sh got req=%b stall=%b required 0 0", dmem_req, mem_stall);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    int n = 0;
    int stalls;
    push_exp(8, 1'b0, 5'd6, 32'h0, 2'b10, 1'b0);
    issue(32'h0000_4000, 32'h0, 5'd6, 1'b1, 1'b0, 3'b010, 1'b1);
    while (dmem_req === 1'b1 && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    checks++;
    if (n != 16) begin
      errors++; $display("FAIL timeout_req_cycles got %0d required 16", n);
    end
    @(posedge clk); #1;
    push_exp(9, 1'b1, 5'd6, 32'hCAFE_F00D, 2'b00, 1'b1);
    issue(32'h0000_4000, 32'h0, 5'd6, 1'b1, 1'b0, 3'b010, 1'b1);
    serve(15, 32'hCAFE_F00D, stalls);
    checks++;
    if (stalls != 15) begin
      errors++; $display("FAIL ack_at_limit_stalls got %0d required 15", stalls);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int stalls;
    issue(32'h0000_6000, 32'h0, 5'd4, 1'b1, 1'b0, 3'b010, 1'b1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got req=%b wbv=%b stall=%b required 0 0 0", dmem_req, wb_valid, mem_stall);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    push_exp(10, 1'b1, 5'd9, 32'hFFFF_8001, 2'b00, 1'b1);
    issue(32'h0000_5002, 32'h0, 5'd9, 1'b1, 1'b0, 3'b001, 1'b1);
    checks++;
    if (dmem_req !== 1'b1 || dmem_addr !== 32'h5000 || dmem_be !== 4'b1100) begin
      errors++;
      $display("FAIL post_reset_req got req=%b addr=%h be=%b required 1 00005000 1100",
               dmem_req, dmem_addr, dmem_be);
    end
    serve(2, 32'h8001_0000, stalls);
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int stalls;
    push_exp(11, 1'b1, 5'd10, 32'h1122_3344, 2'b00, 1'b1);
    issue(32'h0000_7000, 32'h0, 5'd10, 1'b1, 1'b0, 3'b010, 1'b1);
    @(posedge clk); #1;
    // Instruction shown during the ack cycle must be dropped.
    dmem_rdata = 32'h1122_3344; dmem_ack = 1'b1;
    ex_valid = 1'b1; ex_alu_result = 32'hDEAD_0000; ex_rd = 5'd11;
    ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_reg_write = 1'b1;
    @(posedge clk); #1;
    dmem_ack = 1'b0; idle_inputs();
    push_exp(12, 1'b1, 5'd12, 32'h0BAD_F00D, 2'b00, 1'b1);
    issue(32'h0BAD_F00D, 32'h0, 5'd12, 1'b0, 1'b0, 3'b000, 1'b1);
    checks++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL b2b_next_accept got wbv=%b data=%h required 1 0badf00d", wb_valid, wb_data);
    end
    // Load to x0: access happens, no register write.
    push_exp(13, 1'b0, 5'd0, 32'h0000_0080, 2'b00, 1'b1);
    issue(32'h0000_1003, 32'h0, 5'd0, 1'b1, 1'b0, 3'b100, 1'b1);
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++; $display("FAIL rd0_access got req=%b required 1", dmem_req);
    end
    serve(0, 32'h80AB_CDEF, stalls);
    @(posedge clk); #1;
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_passthru();
    test_load_byte(3'b000, 32'hFFFF_FF80, 2);
    test_load_byte(3'b100, 32'h0000_0080, 3);
    test_store_half();
    test_misaligned();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL wb_missing got %0d pending required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
